mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between instruction fetch and the data accesses produced by the control unit (dmemr/dmemw) and datapath.
- Sits between the datapath/request logic and the RAM model.
- Grants one requester at a time with data priority and an instruction anti-starvation counter.
- Retries RAM errors, and drains outstanding traffic on halt.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending before instruction is forced.
- RETRY_MAX, 2: RAM ERROR retries per transaction before completing with err.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an abandoned transaction.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction fetch request
- iaddr  input  32  fetch address (word_t)
- dREN  input  1  data read request (dmemr)
- dWEN  input  1  data write request (dmemw)
- daddr  input  32  data address
- dstore  input  32  write data
- halt  input  1  halt from control unit
- ramload  input  32  RAM read data
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- iwait  output  1  low for the completing cycle of a fetch
- dwait  output  1  low for the completing cycle of a data op
- iload  output  32  fetch data, valid when iwait low
- dload  output  32  read data, valid when dwait low
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- err  output  1  sticky: some transaction exhausted retries
- halted  output  1  arbiter drained and parked

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values:
  - state=IDLE, starve_cnt=0, retry_cnt=0, err=0, halted=0.
  - Latched addr/data = 0.
  - ramREN=ramWEN=0, iwait=dwait=1, iload=dload=0.
- States: IDLE, DATA, INSTR, HALTED.
- IDLE:
  - RAM strobes low.
  - Priority on the clock edge:
    - halt with no dREN/dWEN -> HALTED.
    - (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX) -> DATA.
    - iREN -> INSTR.
  - On grant, latch address, dstore and op type.
  - dREN&dWEN together is treated as a write.
- DATA/INSTR:
  - Drive ramaddr/ramstore/strobe from the latched values.
  - ramstate ACCESS:
    - The granted wait goes low combinationally that cycle.
    - load = ramload.
    - Next state IDLE; retry_cnt cleared.
  - ramstate ERROR:
    - If retry_cnt<RETRY_MAX: retry_cnt+1, strobes drop for one cycle (re-issue), stay in state.
    - Otherwise: complete as ACCESS with load=ERR_WORD and set err.
  - BUSY/FREE: hold.
- Minimum latency: request -> 1 cycle grant -> RAM latency. With a zero-wait RAM, wait is low in the second cycle.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each DATA grant while iREN is high.
  - Cleared on INSTR grant or when iREN is low in IDLE.
- Requester deasserts its request mid-transaction: abort, strobes low next cycle, return to IDLE, no wait pulse.
- halt during DATA/INSTR: finish the current transaction first. Pending data requests are still served; fetches are not granted once halt is high.
- HALTED: all strobes low, waits high, halted=1. Exit only by reset.
- Reset mid-transaction: strobes drop asynchronously, no completion reported.
- Back-to-back requests: each completion is followed by one IDLE cycle, so there is no zero-cycle re-grant.

Decomposition:
- Shared package cpu_types_pkg: ramstate_t (existing); add arbstate_t {IDLE, DATA, INSTR, HALTED}.
- Interface mem_arbiter_if, with modports arb and tb.
- No sub-module needed; the starvation/retry counters are kept inline.

Test Plan:
- Fetch only: iREN=1, iaddr=0x40, RAM ACCESS on its 2nd cycle with ramload=0x00A00093 -> ramREN=1 at 0x40; iwait low one cycle; iload=0x00A00093; then IDLE.
- Contention: iREN=1 and dREN=1 simultaneously, daddr=0x100 -> DATA granted first (ramaddr=0x100); INSTR granted after dwait pulse plus one IDLE cycle.
- Starvation: iREN held high, 6 consecutive dWEN requests -> 4 data grants, then an INSTR grant, then data resumes.
- Error retry: ramstate=ERROR three times on daddr=0x200 with RETRY_MAX=2 -> two re-issues, then dwait low, dload=0xBAD1BAD1, err=1 and it stays set.
- Halt drain: halt asserted mid-fetch while dWEN is pending -> fetch completes, write completes, no further fetch granted, halted=1 with strobes low.
- Async reset during DATA with ramWEN high -> ramWEN=0 immediately without a clock edge; state IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, word type and memory arbiter states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, DATA, INSTR, HALTED} arbstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's request, response and RAM-side signals.
interface mem_arbiter_if
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic nRST
);
    logic      iREN, dREN, dWEN, halt;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN, err, halted;
    word_t     iload, dload, ramaddr, ramstore;

    modport arb (
        input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err, halted
    );

    modport tb (
        input  CLK, nRST, iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err, halted,
        output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data accesses: data priority,
// fetch anti-starvation, bounded ERROR retries and a drain-then-park halt.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned RETRY_MAX  = 2,
    parameter word_t       ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  logic      halt,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      err,
    output logic      halted
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int unsigned RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    arbstate_t       state;
    logic [SW-1:0]   starve_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            reissue;
    logic            wr;
    word_t           addr_q;
    word_t           data_q;

    logic data_req, fetch_req, starved, req_live, active, give_up, done;

    always_comb begin
        data_req  = dREN | dWEN;
        // Once halt is up, fetches no longer count as pending, so they can never block data.
        fetch_req = iREN & ~halt;
        starved   = fetch_req && (starve_cnt == SW'(STARVE_MAX));
        req_live  = (state == DATA) ? data_req : (state == INSTR) ? iREN : 1'b0;
        active    = req_live && !reissue;
        give_up   = (ramstate == ERROR) && (retry_cnt == RW'(RETRY_MAX));
        done      = active && ((ramstate == ACCESS) || give_up);

        ramREN    = ((state == INSTR) || (state == DATA && !wr)) && !reissue;
        ramWEN    = (state == DATA) && wr && !reissue;
        ramaddr   = addr_q;
        ramstore  = data_q;

        iwait     = !(done && state == INSTR);
        dwait     = !(done && state == DATA);
        iload     = (done && state == INSTR) ? (give_up ? ERR_WORD : ramload) : '0;
        dload     = (done && state == DATA)  ? (give_up ? ERR_WORD : ramload) : '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            retry_cnt  <= '0;
            reissue    <= 1'b0;
            wr         <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            err        <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    reissue   <= 1'b0;
                    retry_cnt <= '0;
                    if (halt && !data_req) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (data_req && !starved) begin
                        state  <= DATA;
                        addr_q <= daddr;
                        data_q <= dstore;
                        wr     <= dWEN;
                        if (!iREN)
                            starve_cnt <= '0;
                        else if (starve_cnt != SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (fetch_req) begin
                        state      <= INSTR;
                        addr_q     <= iaddr;
                        wr         <= 1'b0;
                        starve_cnt <= '0;
                    end else if (!iREN) begin
                        starve_cnt <= '0;
                    end
                end
                DATA, INSTR: begin
                    if (!req_live) begin
                        state     <= IDLE;
                        retry_cnt <= '0;
                        reissue   <= 1'b0;
                    end else if (reissue) begin
                        reissue <= 1'b0;
                    end else if (done) begin
                        state     <= IDLE;
                        retry_cnt <= '0;
                        if (give_up)
                            err <= 1'b1;
                    end else if (ramstate == ERROR) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        reissue   <= 1'b1;
                    end
                end
                default: begin
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and a random run.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int          STARVE_MAX = 4;
    localparam int          RETRY_MAX  = 2;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

    logic        clk = 1'b0;
    logic        nrst;
    logic        iREN, dREN, dWEN, halt;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err, halted;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .RETRY_MAX(RETRY_MAX), .ERR_WORD(ERR_WORD)) dut (
        .CLK(clk), .nRST(nrst),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .halt(halt), .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .err(err), .halted(halted)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    typedef struct {
        logic        i, dr, dw;
        logic [31:0] ia, da, ds, rl;
        ramstate_t   rs;
        logic        e_ren, e_wen;
        logic [31:0] e_addr;
        logic        e_iw, e_dw;
        logic [31:0] e_load;
    } vec_t;

    function automatic vec_t mk(input logic i, input logic dr, input logic dw,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] ds, input logic [31:0] rl, input ramstate_t rs,
                                input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                                input logic e_iw, input logic e_dw, input logic [31:0] e_load);
        vec_t v;
        v.i = i; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr;
        v.e_iw = e_iw; v.e_dw = e_dw; v.e_load = e_load;
        return v;
    endfunction

    // Reference model state (transaction view of the RAM port)
    bit          m_halted, m_busy, m_isdata, m_wr, m_skip;
    int          m_errs, m_streak;
    logic [31:0] m_addr, m_store;
    bit          m_err;

    vec_t  tbl[14];
    string order;
    int    ncomp;
    ramstate_t   rs_seq[5];
    logic        ren_seq[5];
    logic        dw_seq[5];

    initial begin
        nrst = 1'b0;
        idle_inputs();
        #12;
        chk("reset ctl", {iwait, dwait, ramREN, ramWEN, err, halted}, 6'b110000);
        chk("reset data", {ramaddr, ramstore, iload, dload}, 128'h0);
        @(negedge clk);
        nrst = 1'b1;

        // ---- table-driven: fetch, contention, write, read+write-as-write ----
        tbl[0]  = mk(1'b1,1'b0,1'b0,32'h40,32'h0,  32'h0, 32'h0,      FREE,  1'b0,1'b0,32'h0,  1'b1,1'b1,32'h0);
        tbl[1]  = mk(1'b1,1'b0,1'b0,32'h40,32'h0,  32'h0, 32'h0,      BUSY,  1'b1,1'b0,32'h40, 1'b1,1'b1,32'h0);
        tbl[2]  = mk(1'b1,1'b0,1'b0,32'h40,32'h0,  32'h0, 32'h00A00093,ACCESS,1'b1,1'b0,32'h40, 1'b0,1'b1,32'h00A00093);
        tbl[3]  = mk(1'b0,1'b0,1'b0,32'h0, 32'h0,  32'h0, 32'h0,      FREE,  1'b0,1'b0,32'h40, 1'b1,1'b1,32'h0);
        tbl[4]  = mk(1'b1,1'b1,1'b0,32'h44,32'h100,32'h0, 32'h0,      FREE,  1'b0,1'b0,32'h40, 1'b1,1'b1,32'h0);
        tbl[5]  = mk(1'b1,1'b1,1'b0,32'h44,32'h100,32'h0, 32'h11,     ACCESS,1'b1,1'b0,32'h100,1'b1,1'b0,32'h11);
        tbl[6]  = mk(1'b1,1'b0,1'b0,32'h44,32'h0,  32'h0, 32'h0,      FREE,  1'b0,1'b0,32'h100,1'b1,1'b1,32'h0);
        tbl[7]  = mk(1'b1,1'b0,1'b0,32'h44,32'h0,  32'h0, 32'h22,     ACCESS,1'b1,1'b0,32'h44, 1'b0,1'b1,32'h22);
        tbl[8]  = mk(1'b0,1'b0,1'b0,32'h0, 32'h0,  32'h0, 32'h0,      FREE,  1'b0,1'b0,32'h44, 1'b1,1'b1,32'h0);
        tbl[9]  = mk(1'b0,1'b0,1'b1,32'h0, 32'h180,32'h55,32'h0,      FREE,  1'b0,1'b0,32'h44, 1'b1,1'b1,32'h0);
        tbl[10] = mk(1'b0,1'b0,1'b1,32'h0, 32'h180,32'h55,32'h0,      ACCESS,1'b0,1'b1,32'h180,1'b1,1'b0,32'h0);
        tbl[11] = mk(1'b0,1'b1,1'b1,32'h0, 32'h1C0,32'h66,32'h0,      FREE,  1'b0,1'b0,32'h180,1'b1,1'b1,32'h0);
        tbl[12] = mk(1'b0,1'b1,1'b1,32'h0, 32'h1C0,32'h66,32'h0,      ACCESS,1'b0,1'b1,32'h1C0,1'b1,1'b0,32'h0);
        tbl[13] = mk(1'b0,1'b0,1'b0,32'h0, 32'h0,  32'h0, 32'h0,      FREE,  1'b0,1'b0,32'h1C0,1'b1,1'b1,32'h0);

        for (int k = 0; k < 14; k++) begin
            iREN = tbl[k].i; dREN = tbl[k].dr; dWEN = tbl[k].dw;
            iaddr = tbl[k].ia; daddr = tbl[k].da; dstore = tbl[k].ds;
            ramload = tbl[k].rl; ramstate = tbl[k].rs;
            #1;
            chk($sformatf("vec%0d", k), {ramREN, ramWEN, ramaddr, iwait, dwait},
                {tbl[k].e_ren, tbl[k].e_wen, tbl[k].e_addr, tbl[k].e_iw, tbl[k].e_dw});
            if (!tbl[k].e_iw) chk($sformatf("vec%0d iload", k), iload, tbl[k].e_load);
            if (!tbl[k].e_dw) chk($sformatf("vec%0d dload", k), dload, tbl[k].e_load);
            if (tbl[k].e_wen) chk($sformatf("vec%0d store", k), ramstore, tbl[k].ds);
            @(negedge clk);
        end

        // ---- starvation: iREN held, continuous writes, zero-wait RAM ----
        do_reset();
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h300; ramstate = ACCESS;
        order = "";
        ncomp = 0;
        for (int c = 0; c < 60 && ncomp < 7; c++) begin
            @(posedge clk);
            #1;
            if (!dwait) begin order = {order, "D"}; ncomp++; end
            else if (!iwait) begin order = {order, "I"}; ncomp++; end
        end
        total++;
        if (order != "DDDDIDD") begin
            bad++;
            $display("FAIL starve order: got %s expected DDDDIDD", order);
        end

        // ---- error retry: three ERRORs on a read of 0x200 ----
        do_reset();
        dREN = 1'b1; daddr = 32'h200;
        rs_seq  = '{ERROR, FREE, ERROR, FREE, ERROR};
        ren_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        dw_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ramstate = rs_seq[k];
            #1;
            chk($sformatf("retry%0d", k), {ramREN, ramWEN, dwait, err, ramaddr},
                {ren_seq[k], 1'b0, dw_seq[k], 1'b0, 32'h200});
        end
        chk("retry dload", dload, ERR_WORD);
        @(negedge clk);
        dREN = 1'b0; ramstate = FREE;
        #1;
        chk("retry err set", {err, ramREN}, 2'b10);
        repeat (3) @(negedge clk);
        #1;
        chk("retry err sticky", err, 1'b1);

        // ---- halt drain: halt mid-fetch with a write pending ----
        do_reset();
        iREN = 1'b1; iaddr = 32'h80;
        @(negedge clk);
        halt = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hDEAD; ramstate = BUSY;
        #1;
        chk("halt fetch busy", {ramREN, ramWEN, iwait, ramaddr}, {3'b101, 32'h80});
        @(negedge clk);
        ramstate = ACCESS; ramload = 32'h77;
        #1;
        chk("halt fetch done", {iwait, iload}, {1'b0, 32'h77});
        @(negedge clk);
        ramstate = FREE;
        #1;
        chk("halt gap", {ramREN, ramWEN}, 2'b00);
        @(negedge clk);
        ramstate = ACCESS;
        #1;
        chk("halt write", {ramWEN, dwait, ramaddr, ramstore}, {2'b10, 32'h300, 32'hDEAD});
        @(negedge clk);
        dWEN = 1'b0; ramstate = FREE;
        #1;
        chk("halt idle", {ramREN, ramWEN, halted}, 3'b000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("halted%0d", k), {halted, ramREN, ramWEN, iwait, dwait}, 5'b10011);
        end

        // ---- asynchronous reset mid-write ----
        do_reset();
        dWEN = 1'b1; daddr = 32'h400; dstore = 32'h1; ramstate = BUSY;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("arst pre", ramWEN, 1'b1);
        #1;
        nrst = 1'b0;
        #1;
        chk("arst drop", {ramWEN, ramREN, dwait}, 3'b001);
        dWEN = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        #1;
        chk("arst idle", {ramWEN, ramREN, ramaddr}, {2'b00, 32'h0});
        dREN = 1'b1; daddr = 32'h10;
        @(negedge clk);
        #1;
        chk("arst regrant", {ramREN, ramaddr}, {1'b1, 32'h10});

        // ---- random run against the reference model ----
        do_reset();
        m_halted = 0; m_busy = 0; m_isdata = 0; m_wr = 0; m_skip = 0;
        m_errs = 0; m_streak = 0; m_addr = '0; m_store = '0; m_err = 0;
        for (int c = 0; c < 1500; c++) begin
            logic want, on, fin, e_ren, e_wen, e_iw, e_dw;
            logic [31:0] e_load;
            int r;
            if ($urandom_range(0, 5) == 0) iREN = ~iREN;
            if ($urandom_range(0, 5) == 0) dREN = ~dREN;
            if ($urandom_range(0, 7) == 0) dWEN = ~dWEN;
            if (c > 1300 && $urandom_range(0, 49) == 0) halt = 1'b1;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 9);
            ramstate = (r < 4) ? ACCESS : (r < 6) ? BUSY : (r < 8) ? ERROR : FREE;
            #1;
            want   = m_isdata ? (dREN | dWEN) : iREN;
            on     = m_busy && !m_skip;
            fin    = on && want && (ramstate == ACCESS || (ramstate == ERROR && m_errs == RETRY_MAX));
            e_ren  = on && !(m_isdata && m_wr);
            e_wen  = on && m_isdata && m_wr;
            e_iw   = !(fin && !m_isdata);
            e_dw   = !(fin && m_isdata);
            e_load = (ramstate == ACCESS) ? ramload : ERR_WORD;
            chk($sformatf("rand%0d", c), {ramREN, ramWEN, iwait, dwait, err, halted, ramaddr, ramstore},
                {e_ren, e_wen, e_iw, e_dw, m_err, m_halted, m_addr, m_store});
            if (!e_iw) chk($sformatf("rand%0d iload", c), iload, e_load);
            if (!e_dw) chk($sformatf("rand%0d dload", c), dload, e_load);

            if (m_halted) begin
            end else if (!m_busy) begin
                m_skip = 0; m_errs = 0;
                if (halt && !(dREN | dWEN)) begin
                    m_halted = 1;
                end else if ((dREN | dWEN) && !(iREN && !halt && m_streak >= STARVE_MAX)) begin
                    m_busy = 1; m_isdata = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
                    m_streak = iREN ? ((m_streak + 1 > STARVE_MAX) ? STARVE_MAX : m_streak + 1) : 0;
                end else if (iREN && !halt) begin
                    m_busy = 1; m_isdata = 0; m_wr = 0; m_addr = iaddr; m_streak = 0;
                end else if (!iREN) begin
                    m_streak = 0;
                end
            end else if (!want) begin
                m_busy = 0; m_errs = 0; m_skip = 0;
            end else if (m_skip) begin
                m_skip = 0;
            end else if (fin) begin
                m_busy = 0;
                if (ramstate == ERROR) m_err = 1;
                m_errs = 0;
            end else if (ramstate == ERROR) begin
                m_errs++; m_skip = 1;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
